// File: rtl/eeprom_pkg.sv
// eeprom_pkg: shared types and helpers for the EEPROM page controller.
//   state_t     - controller FSM states (poll states only reached with ACKPOLL_EN)
//   ERR_*       - err_code encodings
//   DEV_ID_DEF  - default device-type nibble of the I2C slave byte
//   slave_byte  - builds {dev_id, 1'b0, block_select, rw}
package eeprom_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_ISSUE,
    S_XFER,
    S_WR_WAIT,
    S_DRAIN,
    S_POLL_ISSUE,
    S_POLL_XFER
  } state_t;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_PAGE = 2'd1;
  localparam logic [1:0] ERR_NACK = 2'd2;
  localparam logic [1:0] ERR_OVF  = 2'd3;

  localparam logic [3:0] DEV_ID_DEF = 4'b1010;

  function automatic logic [7:0] slave_byte(input logic [3:0] dev_id,
                                            input logic [1:0] blk,
                                            input logic       rw);
    return {dev_id, 1'b0, blk, rw};
  endfunction

endpackage

// File: rtl/eeprom_page_buf.sv
// eeprom_page_buf: one-page byte buffer shared by both transfer directions.
//   clr        - reset pointers and load count with the command length
//   wr_en/wdata- store a byte at wr_ptr (ignored once count bytes are stored)
//   rd_adv     - advance rd_ptr (ignored once count bytes are read)
//   rdata      - byte at rd_ptr; once all bytes are read it holds the last one
//   wr_last/rd_last - the current write/read completes the page
//   wr_full/rd_done - all count bytes written/read
module eeprom_page_buf #(
  parameter int PAGE_BYTES = 16,
  parameter int PTR_W      = $clog2(PAGE_BYTES) + 1
)(
  input  logic             clk1,
  input  logic             reset,
  input  logic             clr,
  input  logic [PTR_W-1:0] len,
  input  logic             wr_en,
  input  logic [7:0]       wdata,
  input  logic             rd_adv,
  output logic [7:0]       rdata,
  output logic             wr_last,
  output logic             rd_last,
  output logic             wr_full,
  output logic             rd_done
);
  localparam int IW = $clog2(PAGE_BYTES);

  logic [PAGE_BYTES-1:0][7:0] mem;
  logic [PTR_W-1:0]           wr_ptr, rd_ptr, count, rd_idx;

  assign wr_full = (wr_ptr == count);
  assign rd_done = (rd_ptr == count);
  assign wr_last = ((wr_ptr + PTR_W'(1)) == count);
  assign rd_last = ((rd_ptr + PTR_W'(1)) == count);

  // Past the end, point back at the final byte so a late tx_req sees it held.
  assign rd_idx = rd_done ? (rd_ptr - PTR_W'(1)) : rd_ptr;
  assign rdata  = mem[rd_idx[IW-1:0]];

  always_ff @(posedge clk1 or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= len;
    end else begin
      if (wr_en && !wr_full) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_adv && !rd_done) rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // Storage is not reset; contents are only read after being written.
  always_ff @(posedge clk1) begin
    if (wr_en && !wr_full && !clr) mem[wr_ptr[IW-1:0]] <= wdata;
  end

endmodule

// File: rtl/eeprom_page_ctrl.sv
// eeprom_page_ctrl: page-write/page-read command sequencer in front of an
// I2C EEPROM master.
//   host_cmd_*  - command handshake (rw, start address, length 1..PAGE_BYTES)
//   host_w*     - write bytes into the page buffer (FILL)
//   host_r*     - read bytes out of the page buffer (DRAIN)
//   busy/err/err_code - status; err is sticky until the next accepted command
//   i2c_*       - start pulse, slave byte, reg address, length, tx/rx data
// Build option: define ACKPOLL_EN to replace the fixed write-cycle wait by
// ACK polling (zero-length writes every 1024 cycles, error after 64 NACKs).
module eeprom_page_ctrl
  import eeprom_pkg::*;
#(
  parameter int         PAGE_BYTES = 16,
  parameter int         ADDR_W     = 10,
  parameter logic [3:0] DEV_ID     = DEV_ID_DEF,
  parameter int         TWR_CYCLES = 500000
)(
  input  logic              clk1,
  input  logic              reset,
  input  logic              host_cmd_valid,
  output logic              host_cmd_ready,
  input  logic              host_cmd_rw,
  input  logic [ADDR_W-1:0] host_cmd_addr,
  input  logic [4:0]        host_cmd_len,
  input  logic [7:0]        host_wdata,
  input  logic              host_wvalid,
  output logic              host_wready,
  output logic [7:0]        host_rdata,
  output logic              host_rvalid,
  input  logic              host_rready,
  output logic              busy,
  output logic              err,
  output logic [1:0]        err_code,
  output logic              i2c_start,
  output logic              i2c_rw,
  output logic [7:0]        i2c_slave_byte,
  output logic [7:0]        i2c_reg_addr,
  output logic [4:0]        i2c_len,
  output logic [7:0]        i2c_tx_data,
  input  logic              i2c_tx_req,
  input  logic [7:0]        i2c_rx_data,
  input  logic              i2c_rx_valid,
  input  logic              i2c_done,
  input  logic              i2c_nack
);
  localparam int IW    = $clog2(PAGE_BYTES);
  localparam int PTR_W = IW + 1;

`ifdef ACKPOLL_EN
  localparam int POLL_INTERVAL = 1024;
  localparam int POLL_MAX      = 64;
  localparam logic [31:0] WAIT_LOAD = 32'(POLL_INTERVAL - 1);
  logic [5:0] poll_cnt;
`else
  localparam logic [31:0] WAIT_LOAD = 32'(TWR_CYCLES - 1);
`endif

  state_t      state, nxt;
  logic [31:0] wait_cnt;
  logic        cmd_bad;
  logic        buf_clr, buf_wr, buf_rd;
  logic [7:0]  buf_wdata, buf_rdata;
  logic        wr_last, rd_last, wr_full, rd_done;

  // Reject empty commands and any that would wrap inside the EEPROM page.
  assign cmd_bad = (host_cmd_len == 5'd0) ||
                   ((6'(host_cmd_addr[IW-1:0]) + 6'(host_cmd_len)) > 6'(PAGE_BYTES));

  eeprom_page_buf #(.PAGE_BYTES(PAGE_BYTES), .PTR_W(PTR_W)) u_buf (
    .clk1    (clk1),
    .reset   (reset),
    .clr     (buf_clr),
    .len     (PTR_W'(host_cmd_len)),
    .wr_en   (buf_wr),
    .wdata   (buf_wdata),
    .rd_adv  (buf_rd),
    .rdata   (buf_rdata),
    .wr_last (wr_last),
    .rd_last (rd_last),
    .wr_full (wr_full),
    .rd_done (rd_done)
  );

  assign host_cmd_ready = (state == S_IDLE);
  assign busy           = (state != S_IDLE);
  assign host_wready    = (state == S_FILL);
  assign host_rvalid    = (state == S_DRAIN);
  assign host_rdata     = (state == S_DRAIN) ? buf_rdata : 8'h00;
  assign i2c_start      = (state == S_ISSUE) || (state == S_POLL_ISSUE);
  assign i2c_tx_data    = (state == S_XFER && !i2c_rw) ? buf_rdata : 8'h00;

  always_comb begin
    nxt       = state;
    buf_clr   = 1'b0;
    buf_wr    = 1'b0;
    buf_wdata = host_wdata;
    buf_rd    = 1'b0;
    case (state)
      S_IDLE: if (host_cmd_valid && !cmd_bad) begin
        buf_clr = 1'b1;
        nxt     = host_cmd_rw ? S_ISSUE : S_FILL;
      end
      S_FILL: begin
        buf_wr = host_wvalid;
        if (host_wvalid && wr_last) nxt = S_ISSUE;
      end
      S_ISSUE: nxt = S_XFER;
      S_XFER: begin
        if (i2c_rw) begin
          buf_wr    = i2c_rx_valid;
          buf_wdata = i2c_rx_data;
        end else begin
          buf_rd = i2c_tx_req;
        end
        if (i2c_nack)      nxt = S_IDLE;
        else if (i2c_done) nxt = i2c_rw ? S_DRAIN : S_WR_WAIT;
      end
`ifdef ACKPOLL_EN
      S_WR_WAIT: if (wait_cnt == 32'd0) nxt = S_POLL_ISSUE;
      S_POLL_ISSUE: nxt = S_POLL_XFER;
      S_POLL_XFER: begin
        if (i2c_nack)      nxt = (poll_cnt == 6'(POLL_MAX - 1)) ? S_IDLE : S_WR_WAIT;
        else if (i2c_done) nxt = S_IDLE;
      end
`else
      S_WR_WAIT: if (wait_cnt == 32'd0) nxt = S_IDLE;
`endif
      S_DRAIN: begin
        buf_rd = host_rready;
        if (host_rready && rd_last) nxt = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk1 or posedge reset) begin
    if (reset) begin
      state          <= S_IDLE;
      err            <= 1'b0;
      err_code       <= ERR_NONE;
      i2c_rw         <= 1'b0;
      i2c_slave_byte <= 8'h00;
      i2c_reg_addr   <= 8'h00;
      i2c_len        <= 5'd0;
      wait_cnt       <= 32'd0;
`ifdef ACKPOLL_EN
      poll_cnt       <= 6'd0;
`endif
    end else begin
      state <= nxt;
      case (state)
        S_IDLE: if (host_cmd_valid) begin
          err      <= cmd_bad;
          err_code <= cmd_bad ? ERR_PAGE : ERR_NONE;
          // Transfer fields stay frozen from accept through done/nack.
          if (!cmd_bad) begin
            i2c_rw         <= host_cmd_rw;
            i2c_slave_byte <= slave_byte(DEV_ID, host_cmd_addr[9:8], host_cmd_rw);
            i2c_reg_addr   <= host_cmd_addr[7:0];
            i2c_len        <= host_cmd_len;
          end
        end
        S_XFER: begin
          if (i2c_nack) begin
            err      <= 1'b1;
            err_code <= ERR_NACK;
          end else if (i2c_rw && i2c_rx_valid && wr_full) begin
            err      <= 1'b1;
            err_code <= ERR_OVF;
          end
          wait_cnt <= WAIT_LOAD;
`ifdef ACKPOLL_EN
          poll_cnt <= 6'd0;
`endif
        end
        S_WR_WAIT: begin
          if (wait_cnt != 32'd0) wait_cnt <= wait_cnt - 32'd1;
`ifdef ACKPOLL_EN
          else i2c_len <= 5'd0;
`endif
        end
`ifdef ACKPOLL_EN
        S_POLL_XFER: if (i2c_nack) begin
          wait_cnt <= WAIT_LOAD;
          poll_cnt <= poll_cnt + 6'd1;
          if (poll_cnt == 6'(POLL_MAX - 1)) begin
            err      <= 1'b1;
            err_code <= ERR_NACK;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule
